// File: rtl/io_irq_ctrl.sv
// io_irq_ctrl: synchronised, debounced switch/button inputs with per-channel
// edge detection, maskable pending latch, and a registered priority interrupt.
//
// Ports:
//   clk          system clock, all logic on the rising edge
//   reset_n      synchronous active-low reset
//   in_raw       asynchronous switch/button inputs [N_IN-1:0]
//   wEn          bus write enable
//   addr         bus byte address (decoded on addr[31:4], register on addr[3:2])
//   dataIn       bus write data
//   dataOut      registered bus read data
//   interrupt    registered, high while any unmasked pending bit is set
//   interrupt_id registered, 1 + lowest unmasked pending channel, 0 when none
//   irq_ack      one-cycle pulse clearing pending bit interrupt_id-1
module io_irq_ctrl #(
    parameter int          N_IN     = 16,
    parameter int          DEBOUNCE = 4,
    parameter logic [31:0] BASE     = 32'h0000_1000,
    parameter int          ID_W     = 5
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [N_IN-1:0] in_raw,
    input  logic            wEn,
    input  logic [31:0]     addr,
    input  logic [31:0]     dataIn,
    output logic [31:0]     dataOut,
    output logic            interrupt,
    output logic [ID_W-1:0] interrupt_id,
    input  logic            irq_ack
);

    localparam int CW = $clog2(DEBOUNCE + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE - 1);

    logic [N_IN-1:0]   meta;
    logic [N_IN-1:0]   sync;
    logic [N_IN-1:0]   deb;
    logic [N_IN-1:0]   deb_d;
    logic [N_IN-1:0]   pend;
    logic [N_IN-1:0]   mask;
    logic [2*N_IN-1:0] mode;
    logic [CW-1:0]     cnt [N_IN];

    logic [N_IN-1:0]   rise;
    logic [N_IN-1:0]   fall;
    logic [N_IN-1:0]   evt;
    logic [N_IN-1:0]   ack_clr;
    logic [N_IN-1:0]   w1c;
    logic [N_IN-1:0]   act;
    logic [ID_W-1:0]   next_id;
    logic [31:0]       rd_data;
    logic              hit;
    logic              wr;
    logic [1:0]        sel;
    logic              unused;

    assign hit = (addr[31:4] == BASE[31:4]);
    assign wr  = wEn & hit;
    assign sel = addr[3:2];

    assign unused = ^{addr[1:0], dataIn};

    // Two-flop resynchroniser
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            meta <= '0;
            sync <= '0;
        end else begin
            meta <= in_raw;
            sync <= meta;
        end
    end

    // Debounce: accept sync only after DEBOUNCE consecutive differing cycles
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            deb   <= '0;
            deb_d <= '0;
            for (int i = 0; i < N_IN; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            deb_d <= deb;
            for (int i = 0; i < N_IN; i++) begin
                if (sync[i] == deb[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_LAST) begin
                    deb[i] <= sync[i];
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CW'(1);
                end
            end
        end
    end

    assign rise = deb & ~deb_d;
    assign fall = ~deb & deb_d;

    always_comb begin
        evt = '0;
        for (int i = 0; i < N_IN; i++) begin
            evt[i] = (rise[i] & mode[2*i]) | (fall[i] & mode[2*i+1]);
        end
    end

    // Ack clears the channel currently presented; id 0 means nothing to ack
    always_comb begin
        ack_clr = '0;
        if (irq_ack && (interrupt_id != '0)) begin
            for (int i = 0; i < N_IN; i++) begin
                if (interrupt_id == ID_W'(i + 1)) begin
                    ack_clr[i] = 1'b1;
                end
            end
        end
    end

    assign w1c = (wr && sel == 2'd1) ? dataIn[N_IN-1:0] : '0;

    // Pending latch; a new event overrides a same-cycle clear
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pend <= '0;
        end else begin
            pend <= (pend & ~(w1c | ack_clr)) | evt;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            mask <= '1;
            mode <= '1;
        end else if (wr) begin
            if (sel == 2'd2) begin
                mask <= dataIn[N_IN-1:0];
            end
            if (sel == 2'd3) begin
                mode <= dataIn[2*N_IN-1:0];
            end
        end
    end

    assign act = pend & mask;

    // Lowest-numbered active channel wins
    always_comb begin
        next_id = '0;
        for (int i = N_IN - 1; i >= 0; i--) begin
            if (act[i]) begin
                next_id = ID_W'(i + 1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            interrupt    <= 1'b0;
            interrupt_id <= '0;
        end else begin
            interrupt    <= |act;
            interrupt_id <= next_id;
        end
    end

    always_comb begin
        rd_data = '0;
        if (hit) begin
            unique case (sel)
                2'd0:    rd_data = 32'(deb);
                2'd1:    rd_data = 32'(pend);
                2'd2:    rd_data = 32'(mask);
                default: rd_data = 32'(mode);
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            dataOut <= '0;
        end else begin
            dataOut <= rd_data;
        end
    end

endmodule
